// File: rtl/systolic_output_drain.sv
// Snapshots a HIDDEN_SIZE x CONTEXT_LENGTH result matrix and streams it as LANES-wide row-major beats.
// Optional OUTPUT_RELU_EN: clamp negative output elements to zero (snapshot is left unmodified).
module systolic_output_drain #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned HIDDEN_SIZE    = 64,
    parameter int unsigned CONTEXT_LENGTH = 128,
    parameter int unsigned LANES          = 8,
    localparam int unsigned RW = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1,
    localparam int unsigned CW = (CONTEXT_LENGTH > 1) ? $clog2(CONTEXT_LENGTH) : 1
) (
    input  logic                                 clock,
    input  logic                                 rst_n,
    input  logic                                 capture,
    input  logic signed [2*WIDTH-1:0]            Y_in [HIDDEN_SIZE][CONTEXT_LENGTH],
    output logic                                 busy,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [LANES-1:0][2*WIDTH-1:0] out_data,
    output logic [RW-1:0]                        out_row,
    output logic [CW-1:0]                        out_col,
    output logic                                 out_last,
    output logic                                 done
);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    localparam logic [RW-1:0] RowLast    = RW'(HIDDEN_SIZE - 1);
    localparam logic [CW-1:0] ColLast    = CW'(CONTEXT_LENGTH - LANES);
    localparam logic [CW-1:0] ColStep    = CW'(LANES);
    localparam logic          SingleBeat = (HIDDEN_SIZE == 1) && (CONTEXT_LENGTH == LANES);

    state_e                    state;
    logic signed [2*WIDTH-1:0] snapshot [HIDDEN_SIZE][CONTEXT_LENGTH];
    logic signed [2*WIDTH-1:0] elem;
    logic                      wrap;
    logic [RW-1:0]             row_next;
    logic [CW-1:0]             col_next;

    always_comb begin
        wrap     = (out_col == ColLast);
        col_next = wrap ? '0 : out_col + ColStep;
        row_next = wrap ? out_row + RW'(1) : out_row;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (capture) begin
                        state     <= StDrain;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= SingleBeat;
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= StDone;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            out_row   <= '0;
                            out_col   <= '0;
                        end else begin
                            out_row  <= row_next;
                            out_col  <= col_next;
                            out_last <= (row_next == RowLast) && (col_next == ColLast);
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Snapshot only loads on an accepted capture; it needs no reset since out_data is gated.
    always_ff @(posedge clock) begin
        if (state == StIdle && capture) begin
            snapshot <= Y_in;
        end
    end

    always_comb begin
        out_data = '0;
        elem     = '0;
        if (out_valid) begin
            for (int l = 0; l < LANES; l++) begin
                elem = snapshot[out_row][out_col + CW'(l)];
`ifdef OUTPUT_RELU_EN
                out_data[l] = elem[2*WIDTH-1] ? '0 : elem;
`else
                out_data[l] = elem;
`endif
            end
        end
    end

endmodule

// File: tb/tb_systolic_output_drain.sv
// Self-checking bench for systolic_output_drain at H=2, C=4, LANES=2, WIDTH=16.
// Expected beats come from a queue model built directly from the captured matrix.
module tb_systolic_output_drain;

    localparam int W = 16;
    localparam int H = 2;
    localparam int C = 4;
    localparam int L = 2;

    logic                     clock = 1'b0;
    logic                     rst_n;
    logic                     capture;
    logic                     out_ready;
    logic signed [2*W-1:0]    y [H][C];
    logic                     busy;
    logic                     out_valid;
    logic [L-1:0][2*W-1:0]    out_data;
    logic [0:0]               out_row;
    logic [1:0]               out_col;
    logic                     out_last;
    logic                     done;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        int   row;
        int   col;
        int   d1;
        int   d0;
        logic last;
    } beat_t;

    beat_t exp_q[$];
    beat_t tbl [4];

    systolic_output_drain #(
        .WIDTH         (W),
        .HIDDEN_SIZE   (H),
        .CONTEXT_LENGTH(C),
        .LANES         (L)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .capture  (capture),
        .Y_in     (y),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_last (out_last),
        .done     (done)
    );

    always #5 clock = ~clock;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic int lane_exp(int v);
`ifdef OUTPUT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < C; c++) y[r][c] = 10 * r + c;
    endtask

    task automatic fill_const(int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < C; c++) y[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < C; c++) y[r][c] = $urandom;
    endtask

    // Pulse capture for one edge and record the row-major beat list of the matrix it sees.
    task automatic do_capture();
        capture = 1'b1;
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < C; c += L) begin
                beat_t b;
                b.row  = r;
                b.col  = c;
                b.d0   = lane_exp(int'(y[r][c]));
                b.d1   = lane_exp(int'(y[r][c+1]));
                b.last = (r == H - 1) && (c == C - L);
                exp_q.push_back(b);
            end
        end
        tick();
        capture = 1'b0;
    endtask

    task automatic check_beat(string tag, beat_t b);
        check({tag, " valid"}, int'(out_valid), 1);
        check({tag, " busy"}, int'(busy), 1);
        check({tag, " row"}, int'(out_row), b.row);
        check({tag, " col"}, int'(out_col), b.col);
        check({tag, " lane0"}, int'(out_data[0]), b.d0);
        check({tag, " lane1"}, int'(out_data[1]), b.d1);
        check({tag, " last"}, int'(out_last), int'(b.last));
    endtask

    // Called at the sample point right after the last beat transferred.
    task automatic check_done(string tag, bit cap_in_done);
        check({tag, " done valid"}, int'(out_valid), 0);
        check({tag, " done pulse"}, int'(done), 1);
        check({tag, " done busy"}, int'(busy), 1);
        capture = cap_in_done;
        tick();
        capture = 1'b0;
        check({tag, " idle done"}, int'(done), 0);
        check({tag, " idle busy"}, int'(busy), 0);
        check({tag, " idle valid"}, int'(out_valid), 0);
    endtask

    task automatic drain(string tag, int ready_pct, bit dirty);
        int n      = 0;
        int budget = 100;
        while (exp_q.size() > 0 && budget > 0) begin
            bit rdy;
            check_beat($sformatf("%s beat%0d", tag, n), exp_q[0]);
            rdy       = ($urandom_range(0, 99) < ready_pct);
            out_ready = rdy;
            if (dirty) begin
                fill_const(99);
                capture = 1'b1;
            end
            tick();
            if (rdy) begin
                exp_q.delete(0);
                n++;
            end
            budget--;
        end
        check({tag, " beats left"}, exp_q.size(), 0);
        out_ready = 1'($urandom_range(0, 1));
        check_done(tag, dirty);
        capture = 1'b0;
    endtask

    initial begin
        tbl[0] = '{row: 0, col: 0, d1: 1,  d0: 0,  last: 1'b0};
        tbl[1] = '{row: 0, col: 2, d1: 3,  d0: 2,  last: 1'b0};
        tbl[2] = '{row: 1, col: 0, d1: 11, d0: 10, last: 1'b0};
        tbl[3] = '{row: 1, col: 2, d1: 13, d0: 12, last: 1'b1};

        rst_n     = 1'b1;
        capture   = 1'b0;
        out_ready = 1'b0;
        fill_pattern();
        #1 rst_n = 1'b0;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(out_valid), 0);
        check("reset last", int'(out_last), 0);
        check("reset done", int'(done), 0);
        check("reset row", int'(out_row), 0);
        check("reset col", int'(out_col), 0);
        check("reset data", int'(out_data[0]), 0);
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;

        // Basic drain, first capture right after reset release.
        out_ready = 1'b1;
        do_capture();
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("basic beat%0d", i), tbl[i]);
            tick();
        end
        check_done("basic", 1'b0);

        // Three-cycle stall on beat 2.
        do_capture();
        check_beat("stall beat0", tbl[0]);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("stall hold%0d", i), tbl[1]);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check_beat($sformatf("stall beat%0d", i), tbl[i]);
            tick();
        end
        check_done("stall", 1'b0);

        // Capture on the cycle right after done.
        do_capture();
        drain("afterdone", 100, 1'b0);

        // Negative element through the optional ReLU.
        fill_const(7);
        y[0][0] = -5;
        do_capture();
`ifdef OUTPUT_RELU_EN
        check("relu lane0", int'(out_data[0]), 0);
`else
        check("relu lane0", int'(out_data[0]), -5);
`endif
        drain("relu", 60, 1'b0);

        // Overwrite Y_in and hold capture high throughout the drain.
        fill_pattern();
        do_capture();
        drain("ignore", 100, 1'b0 | 1'b1);

        // Asynchronous reset in the middle of beat 3.
        fill_random();
        do_capture();
        out_ready = 1'b1;
        tick();
        tick();
        check_beat("prereset", exp_q[2]);
        rst_n = 1'b0;
        #1;
        check("async valid", int'(out_valid), 0);
        check("async busy", int'(busy), 0);
        check("async done", int'(done), 0);
        check("async row", int'(out_row), 0);
        check("async col", int'(out_col), 0);
        check("async data", int'(out_data[1]), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("postreset valid%0d", i), int'(out_valid), 0);
            check($sformatf("postreset busy%0d", i), int'(busy), 0);
        end
        do_capture();
        drain("restart", 70, 1'b0);

        // Randomized matrices, ready patterns and idle gaps.
        for (int k = 0; k < 8; k++) begin
            fill_random();
            do_capture();
            drain($sformatf("rand%0d", k), int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                check($sformatf("rand%0d gap valid", k), int'(out_valid), 0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/systolic_output_drain.md
SYSTOLIC_OUTPUT_DRAIN -- requirements
Module: systolic_output_drain

Interface
REQ-001 Parameter WIDTH, default 16, activation width; result element width is 2*WIDTH.
REQ-002 Parameter HIDDEN_SIZE, default 64, number of result rows.
REQ-003 Parameter CONTEXT_LENGTH, default 128, number of result columns.
REQ-004 Parameter LANES, default 8, elements per output beat; must divide CONTEXT_LENGTH.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 capture  in  1  single-cycle request to snapshot Y_in.
REQ-008 Y_in  in  HIDDEN_SIZE x CONTEXT_LENGTH x 2*WIDTH signed  result matrix from the systolic array (Y_out).
REQ-009 busy  out  1  high from the cycle after an accepted capture until the drain completes.
REQ-010 out_valid  out  1  beat valid.
REQ-011 out_ready  in  1  downstream accepts the beat.
REQ-012 out_data  out  LANES x 2*WIDTH signed  elements [row][col .. col+LANES-1]; lane 0 = lowest column.
REQ-013 out_row  out  clog2(HIDDEN_SIZE)  row index of the current beat.
REQ-014 out_col  out  clog2(CONTEXT_LENGTH)  first column index of the current beat.
REQ-015 out_last  out  1  high on the final beat of the matrix.
REQ-016 done  out  1  one-cycle pulse after the last beat is accepted.

Function
REQ-017 FSM states: IDLE, DRAIN, DONE.
REQ-018 IDLE: capture=1 copies all of Y_in into an internal snapshot register, clears the row/col counters, and enters DRAIN at that edge.
REQ-019 Latency: capture sampled at edge N -> out_valid=1 with row 0, col 0 during the cycle after edge N.
REQ-020 DRAIN: out_valid=1; a beat transfers only on a rising edge with out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0: out_data, out_row, out_col and out_last hold constant.
REQ-022 Order is row-major: col advances by LANES per transfer; at col=CONTEXT_LENGTH-LANES it wraps to 0 and row increments.
REQ-023 out_last=1 exactly when row=HIDDEN_SIZE-1 and col=CONTEXT_LENGTH-LANES.
REQ-024 Transfer of the last beat -> DONE; out_valid=0 in DONE; done=1 for exactly that one cycle; next edge -> IDLE.
REQ-025 Total beats per capture = HIDDEN_SIZE*CONTEXT_LENGTH/LANES (1024 at defaults).
REQ-026 capture while in DRAIN or DONE is ignored: snapshot, counters and beat order are unaffected; no queueing.
REQ-027 Changes on Y_in after capture do not affect drained data.
REQ-028 busy=1 in DRAIN and DONE, 0 in IDLE.
REQ-029 out_ready while out_valid=0 has no effect.

Reset
REQ-030 rst_n=0 immediately forces IDLE, with busy, out_valid, out_last and done at 0 and out_row, out_col and out_data at 0; a drain in progress is abandoned.
REQ-031 Snapshot contents after reset are don't-care and never reach out_data before the next capture.
REQ-032 The first capture is honoured at the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro OUTPUT_RELU_EN defined: each out_data lane outputs max(element, 0); negative elements become 0 and the snapshot is unchanged.
REQ-034 Macro OUTPUT_RELU_EN undefined: out_data passes signed elements unmodified; the ReLU logic is not compiled.

Verification (HIDDEN_SIZE=2, CONTEXT_LENGTH=4, LANES=2, WIDTH=16)
REQ-035 Y_in[r][c]=10*r+c, capture pulse, out_ready=1 -> 4 consecutive beats: (0,0){0,1}, (0,2){2,3}, (1,0){10,11}, (1,2){12,13}; out_last on beat 4; done=1 on the next cycle; busy=0 after that.
REQ-036 Same data, out_ready low for 3 cycles on beat 2 -> {2,3}, row 0 and col 2 held stable for all 3 cycles; the sequence otherwise matches the first scenario.
REQ-037 Y_in[0][0]=-5, others 7 -> beat 1 lane 0 = 0 with OUTPUT_RELU_EN defined, = -5 (0xFFFFFFFB) with it undefined.
REQ-038 Capture, then overwrite Y_in with all 99 and pulse capture during beat 2 -> all beats carry the original data; exactly 4 beats; one done pulse.
REQ-039 rst_n low during beat 3 -> out_valid, busy and done are 0 asynchronously, before the next edge; after release with no capture out_valid stays 0; a new capture restarts at row 0, col 0.
REQ-040 Capture on the cycle after done -> accepted; a fresh 4-beat drain follows with out_valid at the expected latency.
